egress_scheduler: RTL and testbench

Output-side read scheduler for the shared-cache switch: sits directly downstream of the switch module. For each output port it picks a non-empty source queue in the second-stage VOQ, issues the VOQ read (`rd_en`/`rd_sel`), captures the returned data into a small per-port output FIFO, and presents it as a valid/ready stream tagged with its source port. One instance serves all `PORT_NUB_TOTAL` output ports.

---
 rtl/egress_scheduler_pkg.sv | 6 +
 rtl/egress_scheduler_rr_arbiter.sv | 23 ++
 rtl/egress_scheduler.sv | 81 ++++++++
 tb/tb_egress_scheduler.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/egress_scheduler_pkg.sv
// egress_scheduler_pkg: shared default sizes for the egress scheduler and its round-robin arbiter
package egress_scheduler_pkg;
  localparam int DEF_PORT_NUB_TOTAL = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_OFIFO_DEPTH = 4;
endpackage

// File: rtl/egress_scheduler_rr_arbiter.sv
// rr_arbiter: combinational N-way round robin; req/ptr in, first requester after ptr out as gnt_idx with gnt_any
module rr_arbiter
  import egress_scheduler_pkg::*;
#(
  parameter int N = DEF_PORT_NUB_TOTAL,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_any
);
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = N; i >= 1; i--) begin
      if (req[ptr + W'(i)]) begin
        gnt_idx = ptr + W'(i);
        gnt_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/egress_scheduler.sv
// egress_scheduler: per-output VOQ read scheduler (voq_empty/voq_data in, rd_en/rd_sel out) feeding per-port {src,data} FIFOs exposed as out_valid/out_ready/out_data/out_src streams
module egress_scheduler
  import egress_scheduler_pkg::*;
#(
  parameter int PORT_NUB_TOTAL = DEF_PORT_NUB_TOTAL,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int OFIFO_DEPTH = DEF_OFIFO_DEPTH,
  localparam int N = PORT_NUB_TOTAL,
  localparam int WIDTH_SEL = $clog2(PORT_NUB_TOTAL)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N*N-1:0]            voq_empty,
  input  logic [DATA_WIDTH*N-1:0]   voq_data,
  output logic [N-1:0]              rd_en,
  output logic [WIDTH_SEL*N-1:0]    rd_sel,
  output logic [N-1:0]              out_valid,
  input  logic [N-1:0]              out_ready,
  output logic [DATA_WIDTH*N-1:0]   out_data,
  output logic [WIDTH_SEL*N-1:0]    out_src
);
  localparam int AW = $clog2(OFIFO_DEPTH);
  localparam int FW = WIDTH_SEL + DATA_WIDTH;
  logic live;
  always_ff @(posedge clk or posedge rst)
    if (rst) live <= 1'b0;
    else live <= 1'b1;
  for (genvar o = 0; o < N; o++) begin : g_port
    logic [WIDTH_SEL-1:0] sel_q, ptr_q, pend_src, gnt_idx;
    logic                 en_q, pend, gnt_any, grant, push, pop, credit_ok;
    logic [N-1:0]         elig;
    logic [AW-1:0]        wp, rp;
    logic [AW:0]          cnt;
    logic [AW+1:0]        used;
    logic [FW-1:0]        mem [OFIFO_DEPTH];
    always_comb begin
      elig = ~voq_empty[o*N +: N];
      if (en_q) elig[sel_q] = 1'b0;
    end
    rr_arbiter #(.N(N)) u_arb (
      .req(elig),
      .ptr(ptr_q),
      .gnt_idx(gnt_idx),
      .gnt_any(gnt_any)
    );
    assign pop = out_valid[o] & out_ready[o];
    assign push = pend;
    assign used = (AW+2)'(cnt) - (AW+2)'(pop) + (AW+2)'(pend) + (AW+2)'(en_q);
    assign credit_ok = used < (AW+2)'(OFIFO_DEPTH);
    assign grant = live & gnt_any & credit_ok;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        en_q <= 1'b0;
        sel_q <= '0;
        ptr_q <= WIDTH_SEL'(N - 1);
        pend <= 1'b0;
        pend_src <= '0;
        wp <= '0;
        rp <= '0;
        cnt <= '0;
      end else begin
        en_q <= grant;
        if (grant) begin
          sel_q <= gnt_idx;
          ptr_q <= gnt_idx;
        end
        pend <= en_q;
        pend_src <= sel_q;
        if (push) wp <= wp + 1'b1;
        if (pop) rp <= rp + 1'b1;
        cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      end
    always_ff @(posedge clk)
      if (push) mem[wp] <= {pend_src, voq_data[o*DATA_WIDTH +: DATA_WIDTH]};
    assign rd_en[o] = en_q;
    assign rd_sel[o*WIDTH_SEL +: WIDTH_SEL] = sel_q;
    assign out_valid[o] = cnt != '0;
    assign {out_src[o*WIDTH_SEL +: WIDTH_SEL], out_data[o*DATA_WIDTH +: DATA_WIDTH]} = out_valid[o] ? mem[rp] : '0;
    a_no_ovf: assert property (@(posedge clk) disable iff (rst) !(push && !pop && cnt == (AW+1)'(OFIFO_DEPTH)));
  end
endmodule

// File: tb/tb_egress_scheduler.sv
// tb_egress_scheduler: randomized check of egress_scheduler against a queue-based reference model
module tb_egress_scheduler;
  localparam int N = 4;
  localparam int DW = 8;
  localparam int WS = 2;
  localparam int DEPTH = 4;
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N*N-1:0]    voq_empty = '1;
  logic [DW*N-1:0]   voq_data = '0;
  logic [N-1:0]      rd_en;
  logic [WS*N-1:0]   rd_sel;
  logic [N-1:0]      out_valid;
  logic [N-1:0]      out_ready = '0;
  logic [DW*N-1:0]   out_data;
  logic [WS*N-1:0]   out_src;
  int n_cmp = 0, n_err = 0;
  int fifo_q[N][$];
  int voq_q[N][N][$];
  int m_en[N], m_sel[N], m_ptr[N], m_pend[N], m_pend_w[N], m_live;
  int rdy_pct[N];
  int fill_pct = 0, src_mask = 0;
  egress_scheduler #(.PORT_NUB_TOTAL(N), .DATA_WIDTH(DW), .OFIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .voq_empty(voq_empty),
    .voq_data(voq_data),
    .rd_en(rd_en),
    .rd_sel(rd_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_src(out_src)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int o = 0; o < N; o++) begin
      fifo_q[o].delete();
      m_en[o] = 0;
      m_sel[o] = 0;
      m_ptr[o] = N - 1;
      m_pend[o] = 0;
      m_pend_w[o] = 0;
    end
    m_live = 0;
  endtask
  task automatic step();
    for (int o = 0; o < N; o++) begin
      int pop, used, g;
      pop = (fifo_q[o].size() > 0 && out_ready[o]) ? 1 : 0;
      used = fifo_q[o].size() - pop + m_pend[o] + m_en[o];
      g = -1;
      for (int k = 1; k <= N; k++) begin
        int s;
        s = (m_ptr[o] + k) % N;
        if (g < 0 && voq_q[o][s].size() > 0 && !(m_en[o] != 0 && m_sel[o] == s)) g = s;
      end
      if (pop != 0) void'(fifo_q[o].pop_front());
      if (m_pend[o] != 0) fifo_q[o].push_back(m_pend_w[o]);
      m_pend[o] = m_en[o];
      if (m_en[o] != 0) m_pend_w[o] = m_sel[o] * 256 + voq_q[o][m_sel[o]].pop_front();
      m_en[o] = (m_live != 0 && g >= 0 && used < DEPTH) ? 1 : 0;
      if (m_en[o] != 0) begin
        m_sel[o] = g;
        m_ptr[o] = g;
      end
    end
    m_live = 1;
  endtask
  task automatic run_cycle();
    for (int o = 0; o < N; o++) begin
      check($sformatf("rd_en[%0d]", o), rd_en[o], m_en[o]);
      check($sformatf("rd_sel[%0d]", o), rd_sel[o*WS +: WS], m_sel[o]);
      check($sformatf("out_valid[%0d]", o), out_valid[o], fifo_q[o].size() > 0 ? 1 : 0);
      if (fifo_q[o].size() > 0) begin
        check($sformatf("out_data[%0d]", o), out_data[o*DW +: DW], fifo_q[o][0] % 256);
        check($sformatf("out_src[%0d]", o), out_src[o*WS +: WS], fifo_q[o][0] / 256);
      end
    end
    for (int o = 0; o < N; o++)
      for (int s = 0; s < N; s++)
        if (src_mask[s] && voq_q[o][s].size() < 6 && $urandom_range(99) < fill_pct)
          voq_q[o][s].push_back($urandom_range(255));
    for (int o = 0; o < N; o++) begin
      out_ready[o] = $urandom_range(99) < rdy_pct[o];
      voq_data[o*DW +: DW] = m_pend[o] != 0 ? DW'(m_pend_w[o]) : DW'($urandom);
      for (int s = 0; s < N; s++) voq_empty[o*N+s] = voq_q[o][s].size() == 0;
    end
    step();
  endtask
  task automatic phase(int cycles, int fill, int mask, int r0, int r1, int r2, int r3);
    fill_pct = fill;
    src_mask = mask;
    rdy_pct = '{r0, r1, r2, r3};
    repeat (cycles) begin
      @(negedge clk);
      run_cycle();
    end
  endtask
  task automatic mid_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_rd_en", rd_en, 0);
    check("arst_out_valid", out_valid, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("arst_out_data", out_data, 0);
    check("arst_out_src", out_src, 0);
    run_cycle();
  endtask
  initial begin
    model_reset();
    rdy_pct = '{0, 0, 0, 0};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_out_data", out_data, 0);
    check("rst_out_src", out_src, 0);
    run_cycle();
    phase(40, 40, 4'b0100, 100, 100, 100, 100);
    phase(60, 70, 4'b1111, 100, 100, 100, 100);
    phase(15, 0, 4'b0000, 100, 100, 100, 100);
    phase(20, 80, 4'b1111, 0, 0, 0, 0);
    phase(1, 80, 4'b1111, 100, 100, 100, 100);
    phase(10, 80, 4'b1111, 0, 0, 0, 0);
    phase(60, 60, 4'b1111, 100, 100, 100, 0);
    phase(300, 35, 4'b1111, 50, 70, 30, 90);
    mid_reset();
    phase(100, 50, 4'b1011, 60, 100, 40, 80);
    phase(20, 0, 4'b0000, 100, 100, 100, 100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
